sreg_serializer: RTL and testbench
==================================

# sreg_serializer

Parallel-to-serial feeder that sits directly upstream of the 8-bit enable-gated shift register. It accepts one word over a valid/ready handshake and emits it LSB-first as a `d`/`en` bit stream, with a programmable bit period. After the last pulse, the downstream register holds the word unchanged in `out[WIDTH-1:0]`. A one-cycle `done` strobe marks frame completion.

## Interface
- `WIDTH`, 8: word length; equals the downstream register's `MSB`.
- `DIV_W`, 4: width of the bit-period divider field.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  word to serialize; sampled on acceptance.
- `valid_in`  in  1  word available.
- `ready_out`  out  1  block can accept; high only in IDLE with `clr` low.
- `div`  in  DIV_W  bit period minus one; sampled on acceptance.
- `clr`  in  1  synchronous abort; returns the block to IDLE.
- `sd_out`  out  1  serial data; drives downstream `d`.
- `sen_out`  out  1  one-cycle shift pulse per bit; drives downstream `en`.
- `busy`  out  1  high in SHIFT or DONE.
- `done`  out  1  one-cycle frame-complete strobe.

## Operation
- **Reset values:** state IDLE, `sd_out`=0, `sen_out`=0, `done`=0, `busy`=0, `ready_out`=1. All internal counters and the shift register are 0.
- **IDLE**
  - `valid_in && ready_out` at an edge captures `data_in` into `shreg`, `div` into `div_q` and `divcnt`, and sets `bitcnt`=0.
  - Next state is SHIFT.
- **SHIFT**, each edge:
  - If `divcnt`≠0: decrement `divcnt`.
  - Else: register `sen_out`=1 and `sd_out`=`shreg[0]`; shift `shreg` right; increment `bitcnt`; reload `divcnt`=`div_q`.
  - When the pulse issued is bit WIDTH-1, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `sen_out` is registered and returns to 0 on every edge that does not issue a bit.
- `sd_out` holds its last value between pulses.
- Bit order: LSB first. This order leaves the word unmodified in the right-shifting downstream register.
- `bitcnt` width is $clog2(WIDTH+1). `divcnt` is DIV_W bits and never wraps below 0.
- `valid_in` outside IDLE is ignored. No word is queued.
- Changes to `div` or `data_in` mid-frame have no effect.
- **`clr`** has priority over everything except `rstn`. At the next edge: state IDLE, `sen_out`=0, `done`=0, counters cleared. No partial `done` is issued. `ready_out` is low while `clr` is high.
- Simultaneous `clr` and `valid_in` in IDLE: the word is not accepted.
- **`rstn` low mid-frame:** all outputs go to their reset values immediately, with no clock required. The frame is lost.

## Timing
- Take the acceptance edge as edge 0, with P = `div`+1.
- `sen_out` is high in the cycles following edges P, 2P, …, WIDTH·P. Bit k is on `sd_out` in the cycle after edge (k+1)·P.
- `done` is high in the same cycle as the final `sen_out` pulse, i.e. after edge WIDTH·P.
- `ready_out` rises after edge WIDTH·P+1. The earliest next acceptance is edge WIDTH·P+2.
- Frame-to-frame throughput is one word per WIDTH·P+2 cycles.
- Downstream samples `d`/`en` on the same `clk`. Its `out` equals the word after edge WIDTH·P+1.

## Structure
- **Shared package `sreg_pkg`:** state enum {IDLE, SHIFT, DONE}, default `WIDTH`=8, default `DIV_W`=4.
- **One sub-module, `bit_tick_gen`:** the `divcnt` down-counter with reload. It emits a `tick` when the count is 0 and enabled, and is cleared by `clr`/`rstn`.
- The FSM, `shreg` and `bitcnt` live in the top module.

## Test plan
- 0xA5, `div`=0 → `sen_out` is high in 8 consecutive cycles after edges 1–8; `sd_out`=1,0,1,0,0,1,0,1; `done` after edge 8; downstream `out`=0xA5.
- 0x3C, `div`=3 → pulses after edges 4, 8, …, 32 only; `done` after edge 32; `ready_out` high after edge 33; `out`=0x3C.
- 0xFF then 0x00 back-to-back with `valid_in` held high → second acceptance at edge 10 (`div`=0); `valid_in` pulsed during the first frame is ignored; final `out`=0x00.
- 0x81, `div`=1, `clr` asserted after the 3rd pulse → no further `sen_out`, no `done`, IDLE at the next edge; a subsequent 0x42 serializes correctly.
- `rstn` dropped mid-frame between edges → `sen_out`/`done`/`busy` go to 0 asynchronously and `ready_out` to 1; after release, 0x5A with `div`=2 completes in 24 cycles.
- `div` changed from 0 to 7 mid-frame → the period stays 1 cycle for that frame and becomes 8 for the next.

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared definitions for the enable-gated shift-register serializer.
package sreg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sreg_serializer_bit_tick_gen.sv
// Bit-period down-counter: loads on frame acceptance, ticks at zero, reloads after each tick.
module bit_tick_gen
    import sreg_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             enable,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] divcnt;

    assign tick = enable && (divcnt == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            divcnt <= '0;
        end else if (clr) begin
            divcnt <= '0;
        end else if (load) begin
            divcnt <= load_val;
        end else if (enable) begin
            if (divcnt == '0) begin
                divcnt <= reload_val;
            end else begin
                divcnt <= divcnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/sreg_serializer.sv
// Parallel-to-serial feeder for a right-shifting enable-gated register: LSB-first d/en stream.
module sreg_serializer
    import sreg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             sd_out,
    output logic             sen_out,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH + 1);

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
    logic [DIV_W-1:0] div_q;
    logic             accept;
    logic             tick;
    logic             last_bit;

    assign ready_out = (state == IDLE) && !clr;
    assign accept    = valid_in && ready_out;
    assign busy      = (state != IDLE);
    // done is a pure state decode, so clr or rstn can never leave a stray strobe.
    assign done      = (state == DONE);
    assign last_bit  = (bitcnt == BIT_W'(WIDTH - 1));

    bit_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .load      (accept),
        .load_val  (div),
        .enable    ((state == SHIFT) && !clr),
        .reload_val(div_q),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            div_q   <= '0;
            sd_out  <= 1'b0;
            sen_out <= 1'b0;
        end else begin
            sen_out <= 1'b0;
            if (clr) begin
                // sd_out keeps its last level; only the pulse and counters are cleared.
                state  <= IDLE;
                bitcnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shreg  <= data_in;
                            div_q  <= div;
                            bitcnt <= '0;
                            state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            sen_out <= 1'b1;
                            sd_out  <= shreg[0];
                            shreg   <= {1'b0, shreg[WIDTH-1:1]};
                            bitcnt  <= bitcnt + BIT_W'(1);
                            if (last_bit) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sreg_serializer.sv
// Directed bench: serializer driving a behavioural model of the downstream shift register.
module tb_sreg_serializer;

    logic       clk;
    logic       rstn;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] div;
    logic       clr;
    logic       sd_out;
    logic       sen_out;
    logic       busy;
    logic       done;
    logic [7:0] ds_out;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] data;
        logic [3:0] div;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    sreg_serializer dut (
        .clk      (clk),
        .rstn     (rstn),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .div      (div),
        .clr      (clr),
        .sd_out   (sd_out),
        .sen_out  (sen_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 8-bit enable-gated right-shifting register.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ds_out <= 8'h00;
        else if (sen_out) ds_out <= {sd_out, ds_out[7:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one word and takes the acceptance edge (edge 0).
    task automatic accept_word(input logic [7:0] w, input logic [3:0] d);
        data_in  = w;
        div      = d;
        valid_in = 1'b1;
        check("ready_before_accept", 32'(ready_out), 32'd1);
        step();
        valid_in = 1'b0;
    endtask

    // Checks edges 1 .. 8P+1 after acceptance against the frame timing.
    task automatic check_frame(input logic [7:0] word, input int p);
        logic exp_sen;
        for (int e = 1; e <= 8 * p + 1; e++) begin
            step();
            exp_sen = (e % p == 0) && (e <= 8 * p);
            check("sen_out", 32'(sen_out), 32'(exp_sen));
            if (exp_sen) check("sd_out", 32'(sd_out), 32'(word[e/p-1]));
            check("done", 32'(done), 32'(e == 8 * p));
            check("busy", 32'(busy), 32'(e <= 8 * p));
            check("ready_out", 32'(ready_out), 32'(e == 8 * p + 1));
        end
        check("downstream_out", 32'(ds_out), 32'(word));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        data_in  = 8'h00;
        valid_in = 1'b0;
        div      = 4'd0;
        clr      = 1'b0;

        vecs[0] = '{data: 8'hA5, div: 4'd0,  exp_out: 8'hA5};
        vecs[1] = '{data: 8'h3C, div: 4'd3,  exp_out: 8'h3C};
        vecs[2] = '{data: 8'h5A, div: 4'd2,  exp_out: 8'h5A};
        vecs[3] = '{data: 8'h01, div: 4'd0,  exp_out: 8'h01};
        vecs[4] = '{data: 8'h80, div: 4'd15, exp_out: 8'h80};
        vecs[5] = '{data: 8'hFF, div: 4'd1,  exp_out: 8'hFF};

        #12;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sen", 32'(sen_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sd", 32'(sd_out), 32'd0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            accept_word(vecs[i].data, vecs[i].div);
            check_frame(vecs[i].exp_out, int'(vecs[i].div) + 1);
        end

        // Back-to-back with valid held high; mid-frame data change is ignored.
        data_in  = 8'hFF;
        div      = 4'd0;
        valid_in = 1'b1;
        step();
        data_in = 8'h00;
        check_frame(8'hFF, 1);
        step();
        check("b2b_busy_edge10", 32'(busy), 32'd1);
        check("b2b_ready_edge10", 32'(ready_out), 32'd0);
        valid_in = 1'b0;
        check_frame(8'h00, 1);

        // clr after the third pulse of 0x81 with div=1.
        accept_word(8'h81, 4'd1);
        for (int e = 1; e <= 6; e++) step();
        check("clr_pre_sen", 32'(sen_out), 32'd1);
        clr = 1'b1;
        #1;
        check("clr_ready_low", 32'(ready_out), 32'd0);
        step();
        check("clr_idle_busy", 32'(busy), 32'd0);
        check("clr_sen", 32'(sen_out), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        valid_in = 1'b1;
        data_in  = 8'hE7;
        step();
        check("clr_blocks_accept", 32'(busy), 32'd0);
        valid_in = 1'b0;
        clr      = 1'b0;
        #1;
        check("clr_release_ready", 32'(ready_out), 32'd1);
        for (int e = 0; e < 12; e++) begin
            step();
            check("clr_quiet_sen", 32'(sen_out), 32'd0);
            check("clr_quiet_done", 32'(done), 32'd0);
        end
        accept_word(8'h42, 4'd0);
        check_frame(8'h42, 1);

        // Asynchronous reset mid-frame while a pulse is high.
        accept_word(8'hC3, 4'd1);
        for (int e = 1; e <= 4; e++) step();
        check("rst_mid_pre_sen", 32'(sen_out), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_sen", 32'(sen_out), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(ready_out), 32'd1);
        check("rst_mid_sd", 32'(sd_out), 32'd0);
        #3;
        rstn = 1'b1;
        step();
        accept_word(8'h5A, 4'd2);
        check_frame(8'h5A, 3);

        // div changed mid-frame: old period for this frame, new one for the next.
        accept_word(8'h96, 4'd0);
        div = 4'd7;
        check_frame(8'h96, 1);
        accept_word(8'h69, 4'd7);
        check_frame(8'h69, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
